// File: rtl/mdu_seq.sv
// Multiply/divide sequencer for the E stage. It models multi-cycle occupancy
// and owns the architectural HI/LO registers.
module mdu_seq #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        int_req,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;

    logic        op_md;
    logic        cmd_ok;
    logic        b_zero;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a, mag_b, mag_q, mag_r;
    logic [31:0] div_q, div_r;
    logic [31:0] divu_q, divu_r;

    assign op_md     = (op >= OP_MULT) && (op <= OP_DIVU);
    assign cmd_ok    = start && !int_req;
    assign stall_req = busy_q | (start & op_md & ~int_req);

    // Sign-extended 64-bit multiply: the low 64 bits equal the signed product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes: quotient truncates toward zero, remainder
    // follows the dividend's sign. 0x80000000 / -1 wraps to 0x80000000.
    assign b_zero = (b == 32'd0);
    assign mag_a  = a[31] ? (~a + 32'd1) : a;
    assign mag_b  = b[31] ? (~b + 32'd1) : b;
    assign mag_q  = b_zero ? 32'd0 : (mag_a / mag_b);
    assign mag_r  = b_zero ? 32'd0 : (mag_a % mag_b);
    assign div_q  = (a[31] ^ b[31]) ? (~mag_q + 32'd1) : mag_q;
    assign div_r  = a[31] ? (~mag_r + 32'd1) : mag_r;
    assign divu_q = b_zero ? 32'd0 : (a / b);
    assign divu_r = b_zero ? 32'd0 : (a % b);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_ok) begin
                    case (op)
                        OP_MULT: begin
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                        end
                        OP_MULTU: begin
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                        end
                        OP_DIV: begin
                            pend_hi_d = b_zero ? hi_q : div_r;
                            pend_lo_d = b_zero ? lo_q : div_q;
                        end
                        OP_DIVU: begin
                            pend_hi_d = b_zero ? hi_q : divu_r;
                            pend_lo_d = b_zero ? lo_q : divu_q;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                    if (op_md) begin
                        cnt_d   = ((op == OP_MULT) || (op == OP_MULTU)) ?
                                  CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        busy_d  = 1'b1;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: multi-cycle results are queued at issue and
// checked by a monitor when busy drops; immediate effects are checked inline.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        int_req = 1'b0;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    mdu_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .int_req(int_req), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one command for one cycle; stall_req is checked while it is applied.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] va,
                                 input logic [31:0] vb, input logic ir,
                                 input logic exp_stall);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb; int_req = ir;
        #1;
        checkOutput("stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; int_req = 1'b0;
    endtask

    task automatic issueMd(input logic [2:0] o, input logic [31:0] va,
                           input logic [31:0] vb, input logic [31:0] eh,
                           input logic [31:0] el, input int cyc);
        exp_t e;
        e.hi = eh; e.lo = el; e.cycles = cyc;
        sb.push_back(e);
        applyStimulus(o, va, vb, 1'b0, 1'b1);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        checkOutput("drain", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: counts busy cycles and compares HI/LO when busy falls.
    initial begin : monitor
        int   busy_len;
        logic prev_busy;
        exp_t e;
        busy_len = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_len = 0;
                prev_busy = 1'b0;
            end else if (busy) begin
                busy_len++;
                prev_busy = 1'b1;
            end else if (prev_busy) begin
                prev_busy = 1'b0;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("busy_len", 32'(busy_len), 32'(e.cycles));
                    checkOutput("hi", hi, e.hi);
                    checkOutput("lo", lo, e.lo);
                end
                busy_len = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation timed out");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_stall", {31'd0, stall_req}, 32'd0);
        reset = 1'b0;

        // MULT -2 * 3; HI/LO must hold old values while busy
        issueMd(3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        @(negedge clk);
        checkOutput("mult_busy_mid", {31'd0, busy}, 32'd1);
        checkOutput("mult_hi_old", hi, 32'd0);
        waitDrain();

        issueMd(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
        waitDrain();

        issueMd(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        waitDrain();

        applyStimulus(3'd5, 32'h11, 32'd0, 1'b0, 1'b0);
        applyStimulus(3'd6, 32'h22, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("mt_hi", hi, 32'h11);
        checkOutput("mt_lo", lo, 32'h22);
        checkOutput("mt_busy", {31'd0, busy}, 32'd0);

        // Divide by zero keeps HI/LO after a full-length busy period
        issueMd(3'd4, 32'd7, 32'd0, 32'h11, 32'h22, 10);
        waitDrain();

        issueMd(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10);
        waitDrain();

        applyStimulus(3'd1, 32'd4, 32'd4, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("flush_busy", {31'd0, busy}, 32'd0);
        checkOutput("flush_hi", hi, 32'h0);
        checkOutput("flush_lo", lo, 32'h80000000);

        applyStimulus(3'd5, 32'h12345678, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("mthi_hi", hi, 32'h12345678);
        checkOutput("mthi_busy", {31'd0, busy}, 32'd0);

        // DIV 100/7 in flight; flushes and new commands while busy are ignored
        issueMd(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        repeat (2) @(posedge clk);
        applyStimulus(3'd6, 32'hDEAD, 32'd0, 1'b1, 1'b1);
        applyStimulus(3'd6, 32'hDEAD, 32'd0, 1'b0, 1'b1);
        applyStimulus(3'd1, 32'd9, 32'd9, 1'b0, 1'b1);
        checkOutput("inflight_lo_old", lo, 32'h80000000);
        waitDrain();
        repeat (2) @(negedge clk);
        checkOutput("after_div_busy", {31'd0, busy}, 32'd0);
        checkOutput("after_div_lo", lo, 32'd14);

        // Reset abort during MULT busy
        issueMd(3'd1, 32'd5, 32'd5, 32'd0, 32'd25, 5);
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("post_abort_busy", {31'd0, busy}, 32'd0);
            checkOutput("post_abort_hi", hi, 32'd0);
            checkOutput("post_abort_lo", lo, 32'd0);
        end
        checkOutput("final_queue", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Sequencer for the E-stage multiply/divide resource. Accepts mult/div/mthi/mtlo commands from the E-stage controller and models the multi-cycle occupancy.
- Owns the HI/LO architectural registers and drives `busy` to the hazard controller.
- Suppresses command launch when an interrupt/exception request flushes the E-stage instruction in the same cycle.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10: busy cycles for div/divu (>=1).
- CNT_W, 4: counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage command valid (one cycle per instruction).
- op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- a  input  32  forwarded rs operand.
- b  input  32  forwarded rt operand.
- int_req  input  1  flush of E-stage instruction this cycle (interrupt/exception taken at M).
- busy  output  1  registered; unit occupied.
- stall_req  output  1  combinational; `busy | (start & op in {1..4} & ~int_req)`; feeds the D-stage MDU-related stall.
- hi  output  32  registered HI.
- lo  output  32  registered LO.

Behaviour:
- Reset (sync): state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending result=0.
- States: IDLE and BUSY.
- Launch (IDLE, start=1, op in 1..4, int_req=0):
  - At the edge, compute the result combinationally from a/b and latch it into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES, set busy=1, go to BUSY.
- BUSY: each edge decrements cnt. On the edge where cnt==1:
  - hi<=pend_hi, lo<=pend_lo, busy<=0, go to IDLE.
  - With start at edge T, busy is high for cycles T+1..T+N; the new hi/lo are visible from cycle T+N+1, the same cycle busy reads 0.
- hi/lo are not modified during BUSY; reads during BUSY return the old values. The hazard unit stalls mfhi/mflo, so this is not architecturally visible.
- MTHI/MTLO (IDLE, start=1, int_req=0): write a into hi or lo at that edge. No busy, zero latency; the visible value updates next cycle.
- Arithmetic:
  - MULT: signed 32x32->64; hi=product[63:32], lo=product[31:0].
  - MULTU: same, unsigned.
  - DIV: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned.
  - Divide by zero (DIV or DIVU): busy runs the full DIV_CYCLES, then hi and lo are left unchanged (pending is loaded from the current hi/lo).
- start with int_req=1: command ignored entirely; no state, hi or lo change; stall_req excludes it.
- int_req while BUSY: no effect. The operation is committed and completes normally.
- start while BUSY (any op): ignored, as a defensive measure. The hazard unit should prevent it.
- op NONE/7 with start: no effect.
- reset during BUSY: abort immediately to reset values; the pending result is discarded.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 at edge T -> busy=1 on cycles T+1..T+5; from T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Also DIVU a=7, b=0 with hi=0x11, lo=0x22 beforehand -> 10 busy cycles, then hi=0x11, lo=0x22.
- MULT start with int_req=1 -> busy stays 0, stall_req=0, hi/lo unchanged. Then MTHI a=0x12345678 with int_req=0 -> hi=0x12345678 next cycle, busy never asserted.
- DIV in flight; at busy cycle 3 pulse int_req and start MTLO a=0xDEAD -> both ignored; the division completes on schedule with the correct quotient and lo is not 0xDEAD.
- MULT in flight; assert reset at busy cycle 2 -> next cycle busy=0, hi=lo=0. Holding int_req=0 and start=0 afterwards -> values remain 0 for 10 cycles.
